// File: rtl/membus_arbiter_fsm.sv
// -----------------------------------------------------------------------------
// membus_arbiter_fsm
//
// Shares the external memory port and the GPIO port between two MIPS cores.
// Each core posts a request and holds its access fields stable. The arbiter
// grants one core at a time in round-robin order. It latches that core's
// access, decodes the target from addr[DECODE_BIT] (0 = ext, 1 = GPIO), and
// issues a single-cycle strobe. It then waits for completion and returns read
// data with a one-cycle done pulse. External accesses complete on ready_ext.
// GPIO accesses complete after a fixed GPIO_LAT cycles.
//
// Optional feature, macro MEMBUS_TIMEOUT_EN:
//   When defined, an external access that sees no ready_ext within TIMEOUT
//   WAIT cycles is aborted. The core then gets done with err set.
//   When undefined, external WAIT is unbounded and err0/err1 are tied low.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   requestN, memreadN, memwriteN core N request and access type
//   addrN, writedataN             core N address / write data
//   grantN, doneN, errN           core N ownership, completion, abort flag
//   readdataN                     core N read-data register
//   memread_ext, memwrite_ext     external strobes
//   addr_ext, writedata_ext       external address / write data
//   readdata_ext, ready_ext       external read data / completion
//   memread_gpio, memwrite_gpio   GPIO strobes
//   addr_gpio, writedata_gpio     GPIO address / write data
//   readdata_gpio                 GPIO read data
// -----------------------------------------------------------------------------
module membus_arbiter_fsm #(
  parameter int GPIO_LAT   = 1,
  parameter int TIMEOUT    = 15,
  parameter int DECODE_BIT = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request0,
  input  logic        request1,
  input  logic        memread0,
  input  logic        memread1,
  input  logic        memwrite0,
  input  logic        memwrite1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  writedata0,
  input  logic [7:0]  writedata1,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  readdata0,
  output logic [7:0]  readdata1,
  output logic        memread_ext,
  output logic        memwrite_ext,
  output logic [15:0] addr_ext,
  output logic [7:0]  writedata_ext,
  input  logic [7:0]  readdata_ext,
  input  logic        ready_ext,
  output logic        memread_gpio,
  output logic        memwrite_gpio,
  output logic [15:0] addr_gpio,
  output logic [7:0]  writedata_gpio,
  input  logic [7:0]  readdata_gpio
);

  // The WAIT counter only needs to reach GPIO_LAT-1 (<= 6) unless the
  // timeout feature needs it to reach TIMEOUT-1 (<= 254).
`ifdef MEMBUS_TIMEOUT_EN
  localparam int CNT_W = 8;
`else
  localparam int CNT_W = 3;
`endif

  localparam logic [CNT_W-1:0] GPIO_LAST = CNT_W'(GPIO_LAT - 1);
`ifdef MEMBUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched transaction of the current owner
  logic             r_owner;
  logic             r_last;
  logic [15:0]      r_addr;
  logic             r_rd;
  logic             r_wr;
  logic [7:0]       r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_readdata0;
  logic [7:0]       r_readdata1;
`ifdef MEMBUS_TIMEOUT_EN
  logic             r_err;
`endif

  logic       w_any_req;
  logic       w_owner_next;
  logic       w_tgt_gpio;
  logic       w_noop;
  logic       w_is_read;
  logic       w_wait_done;
  logic       w_abort;
  logic       w_capture;
  logic       w_drive;
  logic [7:0] w_rdata_sel;

  // Arbitration: with both cores requesting, the one that was not served last wins.
  assign w_any_req    = request0 | request1;
  assign w_owner_next = (request0 & request1) ? ~r_last : request1;

  assign w_tgt_gpio  = r_addr[DECODE_BIT];
  assign w_noop      = ~r_rd & ~r_wr;
  // With both memread and memwrite set, the access is treated as a write only.
  assign w_is_read   = r_rd & ~r_wr;
  assign w_rdata_sel = w_tgt_gpio ? readdata_gpio : readdata_ext;
  assign w_capture   = (r_state == S_WAIT) & w_wait_done & w_is_read & ~w_abort;
  assign w_drive     = (r_state == S_ISSUE) | (r_state == S_WAIT) | (r_state == S_RESP);

  assign readdata0 = r_readdata0;
  assign readdata1 = r_readdata1;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of the always blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // WAIT completion: no-op, GPIO fixed latency, or external ready/timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_wait_done = 1'b0;
    w_abort     = 1'b0;
    if (w_noop) begin
      w_wait_done = 1'b1;
    end else if (w_tgt_gpio) begin
      w_wait_done = (r_cnt == GPIO_LAST);
    end else begin
      w_wait_done = ready_ext;
`ifdef MEMBUS_TIMEOUT_EN
      if (!ready_ext && (r_cnt == TIMEOUT_LAST)) begin
        w_wait_done = 1'b1;
        w_abort     = 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_GRANT;
      S_GRANT: w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_wait_done) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs (Moore: derived from state and the latched transaction)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0         = 1'b0;
    grant1         = 1'b0;
    done0          = 1'b0;
    done1          = 1'b0;
    err0           = 1'b0;
    err1           = 1'b0;
    memread_ext    = 1'b0;
    memwrite_ext   = 1'b0;
    addr_ext       = '0;
    writedata_ext  = '0;
    memread_gpio   = 1'b0;
    memwrite_gpio  = 1'b0;
    addr_gpio      = '0;
    writedata_gpio = '0;

    if (r_state != S_IDLE) begin
      grant0 = ~r_owner;
      grant1 = r_owner;
    end

    if (r_state == S_RESP) begin
      done0 = ~r_owner;
      done1 = r_owner;
`ifdef MEMBUS_TIMEOUT_EN
      err0  = ~r_owner & r_err;
      err1  = r_owner & r_err;
`endif
    end

    // Only the decoded target sees address/data; the other port stays at 0.
    if (w_drive) begin
      if (w_tgt_gpio) begin
        addr_gpio      = r_addr;
        writedata_gpio = r_wdata;
        if (r_state == S_ISSUE) begin
          memread_gpio  = w_is_read;
          memwrite_gpio = r_wr;
        end
      end else begin
        addr_ext      = r_addr;
        writedata_ext = r_wdata;
        if (r_state == S_ISSUE) begin
          memread_ext  = w_is_read;
          memwrite_ext = r_wr;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction latch and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner <= w_owner_next;
        r_addr  <= w_owner_next ? addr1      : addr0;
        r_rd    <= w_owner_next ? memread1   : memread0;
        r_wr    <= w_owner_next ? memwrite1  : memwrite0;
        r_wdata <= w_owner_next ? writedata1 : writedata0;
      end
      if (r_state == S_RESP) r_last <= r_owner;
    end
  end

  // ---------------------------------------------------------------------------
  // WAIT cycle counter: zero on entry to WAIT, cleared whenever outside WAIT
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_cnt <= '0;
    else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
    else                       r_cnt <= '0;
  end

`ifdef MEMBUS_TIMEOUT_EN
  // Abort flag: its value at WAIT exit is held through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_err <= 1'b0;
    else if (r_state == S_WAIT) r_err <= w_abort;
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-core read-data registers: updated only when a read completes normally
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata0 <= '0;
      r_readdata1 <= '0;
    end else if (w_capture) begin
      if (r_owner) r_readdata1 <= w_rdata_sel;
      else         r_readdata0 <= w_rdata_sel;
    end
  end

endmodule

// File: doc/membus_arbiter_fsm.md
Name: membus_arbiter_fsm

Overview:
Transaction-level bus controller that shares the external memory port and the GPIO port between the two MIPS cores. Each core posts a request with its access fields held stable. The block grants one core at a time using round-robin arbitration, decodes the target, issues a single-cycle strobe and waits for completion (ready handshake for external memory, fixed latency for GPIO). It then returns read data and a one-cycle done pulse to the owning core.

Parameters:
GPIO_LAT, 1, cycles spent in WAIT for a GPIO access (legal range 1..7).
TIMEOUT, 15, maximum WAIT cycles for an external access before abort (used only with the timeout feature; legal range 1..255).
DECODE_BIT, 9, address bit selecting the target: 0 = external memory, 1 = GPIO.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
request0, request1  in  1  core request; held high until that core's done.
memread0, memread1  in  1  read access.
memwrite0, memwrite1  in  1  write access.
addr0, addr1  in  16  access address.
writedata0, writedata1  in  8  write data.
grant0, grant1  out  1  core owns the bus, from GRANT through RESP.
done0, done1  out  1  one-cycle completion pulse.
err0, err1  out  1  completion was a timeout abort; valid with done.
readdata0, readdata1  out  8  per-core read data register.
memread_ext, memwrite_ext  out  1  external memory strobes.
addr_ext  out  16  external memory address.
writedata_ext  out  8  external memory write data.
readdata_ext  in  8  external memory read data.
ready_ext  in  1  external memory access complete.
memread_gpio, memwrite_gpio  out  1  GPIO strobes.
addr_gpio  out  16  GPIO address.
writedata_gpio  out  8  GPIO write data.
readdata_gpio  in  8  GPIO read data.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0; readdata0/1 are 0.
  - Round-robin pointer last = 1, so core 0 wins the first contention.
  - A transaction in flight is dropped; no done is issued.
- FSM states: IDLE -> GRANT -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: on a rising edge with any request high, choose the owner:
  - Only one request high: that core.
  - Both high: the core not equal to last.
  - Latch the owner's addr, memread, memwrite and writedata into internal registers, then go to GRANT.
- GRANT: the owner's grant goes to 1. Target = latched addr[DECODE_BIT]. Go to ISSUE.
- ISSUE (exactly one cycle):
  - Target memread/memwrite = latched values.
  - memread and memwrite both set: write only.
  - Neither set: no strobe; the transaction completes as a no-op.
  - Go to WAIT.
- Target address and write data:
  - Driven from ISSUE through RESP.
  - Forced to 0 in IDLE.
  - The non-selected target's outputs stay 0 throughout.
- WAIT:
  - External target: exit on the first cycle ready_ext = 1. A ready_ext high during ISSUE is ignored.
  - GPIO target: exit after exactly GPIO_LAT cycles.
  - No-op: exit after 1 cycle.
  - On exit from a read, the owner's readdata register captures the target's readdata.
- RESP (one cycle):
  - Owner's done = 1; err = 0 unless aborted.
  - last <= owner.
  - Next state IDLE; grant drops on entering IDLE.
- Minimum latency: request sampled at edge N -> grant at N+1 -> strobe at N+2 -> done at N+4 (ext with immediate ready, or GPIO with GPIO_LAT = 1).
- Back-to-back: a request still high during RESP is re-evaluated only in IDLE. The minimum gap between done and the next grant is one IDLE cycle.
- A request dropped mid-transaction does not abort; the transaction completes and done still pulses.
- readdata0/1 hold their value until that core's next read completes. Writes leave them unchanged.
- A core's request and access fields changing after the latch have no effect on the current transaction.

Optional Feature:
Macro: MEMBUS_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT for external accesses. When it reaches TIMEOUT with ready_ext still 0:
  - Go to RESP with err = 1 and done = 1.
  - readdata is not updated.
  - The counter clears on leaving WAIT.
- Not defined: there is no counter, WAIT for the external target is unbounded, and err0/err1 are tied to 0.

Test Plan:
- Single read: core0 reads addr 0x0010, ready_ext high 2 cycles after the strobe, readdata_ext = 0xA5 -> one memread_ext strobe with addr_ext = 0x0010, done0 pulses once, readdata0 = 0xA5, grant1 stays 0.
- GPIO write: core1 writes 0x3C to addr 0x0200 with GPIO_LAT = 1 -> memwrite_gpio one cycle, writedata_gpio = 0x3C, all ext strobes 0, done1 at N+4.
- Contention: both cores request continuously, 4 transactions -> grant order 0, 1, 0, 1; never two grants high at once.
- Read+write both set: core0 issues memread = memwrite = 1 to 0x0005 with writedata 0x77 -> memwrite_ext only, readdata0 unchanged.
- Reset mid-WAIT: reset low while ready_ext is withheld -> all outputs 0 immediately, no done; after release, core0 wins the first contention.
- Timeout (MEMBUS_TIMEOUT_EN, TIMEOUT = 15): ready_ext held 0 -> done0 = 1 and err0 = 1 exactly 15 WAIT cycles after ISSUE; readdata0 unchanged; the next request is served normally.
